activation_skew_feeder: RTL and testbench

- Sits directly downstream of Activation_Memory and directly upstream of the systolic array.
- Drives Cal to Activation_Memory for SIZE cycles, samples one activation row per cycle from its Activation_out bus, and re-times the lanes into the diagonal wavefront the systolic array needs (lane k delayed k cycles).
- Flags per-lane validity and signals pass completion to the top-level controller.

---
 rtl/activation_skew_feeder_pkg.sv | 21 ++
 rtl/skew_delay_line.sv | 41 ++++
 rtl/activation_skew_feeder.sv | 90 +++++++++
 tb/tb_activation_skew_feeder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/activation_skew_feeder_pkg.sv
// ============================================================================
// activation_skew_feeder_pkg : shared dimensions and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package activation_skew_feeder_pkg;

  localparam int SIZE   = 8;
  localparam int DATA_W = 7;
  localparam int BUS_W  = SIZE * DATA_W;
  localparam int CNT_W  = $clog2(SIZE + 1);
  localparam int LANE_W = DATA_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/skew_delay_line.sv
// ============================================================================
// skew_delay_line : DEPTH-stage data+valid shift register, zeros on reset
// Rev 1.0
// ============================================================================
`default_nettype none

module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/activation_skew_feeder.sv
// ============================================================================
// activation_skew_feeder : reads SIZE activation rows and skews lane k by k
// cycles into the diagonal wavefront the systolic array consumes.
// Rev 1.0
// ============================================================================
`default_nettype none

module activation_skew_feeder
  import activation_skew_feeder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load_mem_done,
  input  logic             i_start,
  input  logic [BUS_W-1:0] i_act_in,
  output logic             o_cal_out,
  output logic [BUS_W-1:0] o_sa_act,
  output logic [SIZE-1:0]  o_sa_act_valid,
  output logic             o_busy,
  output logic             o_done
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_feed;
  logic             w_drain;
  logic             w_last;

  assign w_feed  = (r_state == ST_FEED);
  assign w_drain = (r_state == ST_DRAIN);
  assign w_last  = (r_cnt == CNT_W'(SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && i_load_mem_done) begin
            r_state <= ST_FEED;
            r_cnt   <= '0;
          end
        end
        ST_FEED: begin
          if (w_last) begin
            r_state <= ST_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_cal_out = w_feed;
  assign o_busy    = w_feed | w_drain;
  assign o_done    = w_drain & w_last;

  // Input is gated outside FEED so drained stages carry zero data with zero valid.
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (k + 1),
      .DATA_W (LANE_W)
    ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_feed),
      .i_data  (w_feed ? i_act_in[k*LANE_W +: LANE_W] : {LANE_W{1'b0}}),
      .o_valid (o_sa_act_valid[k]),
      .o_data  (o_sa_act[k*LANE_W +: LANE_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_activation_skew_feeder.sv
// ============================================================================
// tb_activation_skew_feeder : scoreboard bench for activation_skew_feeder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_activation_skew_feeder;
  import activation_skew_feeder_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             load_mem_done;
  logic             start;
  logic [BUS_W-1:0] act_in;
  logic             cal_out;
  logic [BUS_W-1:0] sa_act;
  logic [SIZE-1:0]  sa_act_valid;
  logic             busy;
  logic             done;

  activation_skew_feeder u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load_mem_done (load_mem_done),
    .i_start         (start),
    .i_act_in        (act_in),
    .o_cal_out       (cal_out),
    .o_sa_act        (sa_act),
    .o_sa_act_valid  (sa_act_valid),
    .o_busy          (busy),
    .o_done          (done)
  );

  typedef struct {
    int               cyc;
    logic [BUS_W-1:0] data;
    logic [SIZE-1:0]  valid;
    logic             cal;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] row_val(input int mode, input int r, input int k);
    case (mode)
      0:       row_val = DATA_W'(r * 8 + k);
      1:       row_val = {DATA_W{1'b1}};
      default: row_val = DATA_W'(r * 13 + k * 5 + 1);
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] junk_bus(input int mode);
    logic [BUS_W-1:0] b;
    if (mode == 1) b = {BUS_W{1'b1}};
    else           b = {$urandom, $urandom};
    return b;
  endfunction

  // Output monitor: scoreboard entry for this cycle, otherwise idle zeros.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sa_act_valid", 72'(sa_act_valid), 72'(e.valid));
        check_eq("sa_act",       72'(sa_act),       72'(e.data));
        check_eq("cal_out",      72'(cal_out),      72'(e.cal));
        check_eq("busy",         72'(busy),         72'(e.busy));
        check_eq("done",         72'(done),         72'(e.done));
      end else begin
        check_eq("idle_outputs", {5'd0, cal_out, busy, done, sa_act_valid, sa_act}, 72'd0);
      end
    end
  end

  // One pass: push the expected 2*SIZE cycles, then play the memory rows.
  // abort_at > 0 asserts reset in that FEED cycle instead of finishing.
  task automatic run_pass(input int mode, input bit extra_starts, input int abort_at);
    int   n;
    exp_t e;
    @(negedge clk);
    n = cyc;
    load_mem_done = 1'b1;
    start  = 1'b1;
    act_in = junk_bus(mode);
    for (int j = 1; j <= 2 * SIZE; j++) begin
      e.cyc   = n + j;
      e.cal   = (j <= SIZE);
      e.busy  = 1'b1;
      e.done  = (j == 2 * SIZE);
      e.valid = '0;
      e.data  = '0;
      for (int k = 0; k < SIZE; k++) begin
        int r;
        r = j - k - 2;
        if (r >= 0 && r < SIZE) begin
          e.valid[k] = 1'b1;
          e.data[k*DATA_W +: DATA_W] = row_val(mode, r, k);
        end
      end
      sb.push_back(e);
    end
    for (int j = 1; j <= 2 * SIZE; j++) begin
      @(negedge clk);
      start = extra_starts && (j == 3 || j == SIZE + 3);
      if (j <= SIZE) begin
        for (int k = 0; k < SIZE; k++) act_in[k*DATA_W +: DATA_W] = row_val(mode, j - 1, k);
      end else begin
        act_in = junk_bus(mode);
      end
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset", {5'd0, cal_out, busy, done, sa_act_valid, sa_act}, 72'd0);
        sb.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_mem_done = 1'b0;
    start  = 1'b0;
    act_in = '0;
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Start without memory loaded must be ignored.
    @(negedge clk);
    act_in = junk_bus(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    run_pass(0, 1'b0, 0);
    repeat (3) @(negedge clk);
    run_pass(1, 1'b0, 0);
    repeat (2) @(negedge clk);
    run_pass(2, 1'b1, 0);
    repeat (2) @(negedge clk);
    run_pass(0, 1'b0, 5);
    load_mem_done = 1'b0;
    repeat (2 * SIZE + 4) @(negedge clk);

    // Back-to-back: second start lands in the cycle right after done.
    run_pass(0, 1'b0, 0);
    run_pass(2, 1'b0, 0);
    start = 1'b0;
    repeat (4) @(negedge clk);

    check_eq("scoreboard_empty", 72'(sb.size()), 72'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
